// File: rtl/usb_crc_serial_if.sv
// Handshake and status bundle for the serial USB CRC engine.
// The master side drives the bit stream and consumes the emitted CRC bits.
interface usb_crc_serial_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             bit_in;
    logic             bit_valid;
    logic             append;
    logic             out_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic [WIDTH-1:0] crc;
    logic             residue_ok;

    modport master (
        output start, bit_in, bit_valid, append, out_ready,
        input  out_bit, out_valid, out_last, busy, crc, residue_ok
    );

    modport slave (
        input  start, bit_in, bit_valid, append, out_ready,
        output out_bit, out_valid, out_last, busy, crc, residue_ok
    );
endinterface

// File: rtl/usb_crc_serial.sv
// Serial CRC engine for the USB bitstream: accumulates LSB-first packet bits,
// emits the inverted CRC MSB-first under ready/valid, and checks the residue.
module usb_crc_serial #(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] POLY    = 5'h05,
    parameter logic [WIDTH-1:0] INIT    = '1,
    parameter logic [WIDTH-1:0] RESIDUE = 5'h0C
) (
    input logic             clk,
    input logic             rst_b,
    usb_crc_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_crc;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_crcNext;
    logic [WIDTH-1:0] w_shiftNext;
    logic [WIDTH-1:0] w_crcAcc;
    logic [CW-1:0]    w_cntNext;
    logic             w_fire;

    function automatic logic [WIDTH-1:0] crcStep(input logic [WIDTH-1:0] c, input logic b);
        logic fb;
        fb = c[WIDTH-1] ^ b;
        return {c[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    assign w_fire = (r_state == EMIT) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_crc   <= INIT;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_crc   <= w_crcNext;
            r_shift <= w_shiftNext;
            r_cnt   <= w_cntNext;
        end
    end

    // A bit arriving together with append is folded in before the shift register loads.
    always_comb begin
        w_stateNext = r_state;
        w_crcNext   = r_crc;
        w_shiftNext = r_shift;
        w_cntNext   = r_cnt;
        w_crcAcc    = bus.bit_valid ? crcStep(r_crc, bus.bit_in) : r_crc;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_stateNext = ACCUM;
                    w_crcNext   = INIT;
                end
            end
            ACCUM: begin
                if (bus.start) begin
                    w_crcNext = INIT;
                end else begin
                    w_crcNext = w_crcAcc;
                    if (bus.append) begin
                        w_stateNext = EMIT;
                        w_shiftNext = ~w_crcAcc;
                        w_cntNext   = CW'(WIDTH - 1);
                    end
                end
            end
            EMIT: begin
                if (w_fire) begin
                    w_shiftNext = {r_shift[WIDTH-2:0], 1'b0};
                    w_crcNext   = crcStep(r_crc, r_shift[WIDTH-1]);
                    w_cntNext   = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.out_valid  = (r_state == EMIT);
    assign bus.out_bit    = (r_state == EMIT) && r_shift[WIDTH-1];
    assign bus.out_last   = (r_state == EMIT) && (r_cnt == '0);
    assign bus.busy       = (r_state != IDLE);
    assign bus.crc        = r_crc;
    assign bus.residue_ok = (r_crc == RESIDUE);
endmodule

// File: doc/usb_crc_serial.md
Name: usb_crc_serial

Overview:
- Parametrised serial CRC engine for the USB bitstream path. One instance covers both CRC5 (token) and CRC16 (data) through parameters.
- Accumulates the unstuffed packet bits LSB-first as they are serialised. On request, it emits the inverted CRC MSB-first with a ready/valid handshake, so the downstream bit-stuffer can stall it.
- Also runs on the receive path: flags whether the register holds the USB residue after data plus CRC have been fed in.

Parameters:
- WIDTH, 5, CRC register width (5 or 16).
- POLY, 5'h05, generator polynomial without the x^WIDTH term (CRC16 instance: 16'h8005).
- INIT, all ones, register value loaded on reset and on start.
- RESIDUE, 5'h0C, good-packet residue (CRC16 instance: 16'h800D).

Ports:
- clk  in  1  system clock
- rst_b  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: load INIT, enter ACCUM
- bit_in  in  1  packet data bit (LSB-first stream order)
- bit_valid  in  1  bit_in is consumed this cycle (ACCUM only)
- append  in  1  one-cycle pulse: enter EMIT and shift out ~crc
- out_bit  out  1  CRC bit being emitted
- out_valid  out  1  out_bit valid
- out_ready  in  1  consumer accepts out_bit
- out_last  out  1  qualifies the final CRC bit (with out_valid)
- busy  out  1  state != IDLE
- crc  out  WIDTH  current register value
- residue_ok  out  1  crc == RESIDUE (combinational from register)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_b. While rst_b==0 at a clk edge:
  - state=IDLE, crc=INIT, bit counter=0;
  - out_valid=0, out_last=0, out_bit=0, busy=0;
  - residue_ok reflects INIT (0 for both standard instances).
- Update rule, one bit per accepted cycle:
  - fb = crc[WIDTH-1] ^ bit_in;
  - crc_next = {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
- States:
  - IDLE: outputs quiet, bit_valid ignored. start -> ACCUM with crc=INIT.
  - ACCUM: each bit_valid cycle applies the update rule; crc is visible the next cycle.
    - append -> EMIT, counter=WIDTH-1, shift register loaded with ~crc. If bit_valid coincides with append, that bit is folded in first and the emitted CRC includes it.
    - start in ACCUM reloads INIT and stays in ACCUM; start has priority over bit_valid.
  - EMIT: out_valid=1 and out_bit=shift[WIDTH-1].
    - On out_valid&&out_ready: shift left, counter decrements, and crc also takes the update rule with out_bit as input. After all WIDTH bits, crc therefore equals RESIDUE.
    - out_last=1 when counter==0. The handshake on that bit -> IDLE the next cycle.
    - out_ready low: out_bit, counter and crc all hold.
    - bit_valid, append and start are ignored in EMIT.
- Latency: append at cycle t -> first out_valid at t+1. An unstalled WIDTH-bit emission occupies cycles t+1..t+WIDTH.
- Receive use: stay in ACCUM and feed data plus received CRC bits through bit_valid; residue_ok is sampled by the caller after the last bit.
- append in IDLE: ignored. Zero-bit packet (start then append) emits ~INIT = all zeros.
- Reset mid-EMIT: out_valid deasserts on that edge; no partial-completion signalling.

Test Plan:
- CRC5, 11 zero bits (addr 0, endp 0), then append, out_ready=1 -> crc=5'b10111 before append; out_bit sequence 0,1,0,0,0; out_last on the 5th bit; crc=5'h0C afterwards; busy drops the cycle after.
- CRC5 receive: 11 zeros then bits 0,1,0,0,0 on bit_valid -> residue_ok=1. Flip any one of those bits -> residue_ok=0.
- CRC16 zero-length DATA: start, append -> 16 zero bits emitted, out_last on the 16th; final crc=16'h800D.
- Backpressure: CRC5 emission with out_ready toggling 1,0,0,1,... -> out_bit and crc stable while stalled; same bit sequence as unstalled; exactly 5 handshakes.
- Simultaneous events:
  - bit_valid=1, bit_in=1 with append in the same cycle -> the emitted CRC includes that bit;
  - start with bit_valid in ACCUM -> crc=INIT;
  - start during EMIT -> ignored.
- Reset: rst_b low during the 3rd emitted bit -> next cycle out_valid=0, busy=0, crc=INIT. Asynchronous glitch of rst_b between edges -> no effect.
